// File: rtl/rx_block_lock_if.sv
// rx_block_lock_if: header stream from block sync plus slip/lock feedback
interface rx_block_lock_if #(
  parameter int HDR_WIDTH    = 2,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16
);
  logic                                i_hdr_valid;
  logic [HDR_WIDTH-1:0]                i_sync_hdr;
  logic                                o_slip;
  logic                                o_block_lock;
  logic [$clog2(SH_CNT_MAX+1)-1:0]     o_sh_cnt;
  logic [$clog2(SH_INVLD_MAX+1)-1:0]   o_invld_cnt;
  modport master (output i_hdr_valid, i_sync_hdr, input o_slip, o_block_lock, o_sh_cnt, o_invld_cnt);
  modport slave  (input i_hdr_valid, i_sync_hdr, output o_slip, o_block_lock, o_sh_cnt, o_invld_cnt);
endinterface

// File: rtl/rx_block_lock.sv
// rx_block_lock: 64b/66b sync-header block-lock state machine driving slip pulses
module rx_block_lock #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_BLANK   = 2,
  parameter int HDR_WIDTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  rx_block_lock_if.slave  bus
);
  localparam int SW = $clog2(SH_CNT_MAX+1);
  localparam int IW = $clog2(SH_INVLD_MAX+1);
  localparam int BW = $clog2(SLIP_BLANK+1);
  typedef enum logic [1:0] {LOCK_INIT, TEST_SH, SLIP_WAIT} state_t;
  state_t state_q, state_d;
  logic lock_q, lock_d, slip_q, slip_d;
  logic [SW-1:0] sh_cnt_q, sh_cnt_d, sh_inc;
  logic [IW-1:0] invld_cnt_q, invld_cnt_d, inv_inc;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic hdr_ok, accept, sh_full, lose, bad_unlocked, blank_done, clear;
  // header qualification and window events shared by both comb processes
  always_comb begin
    hdr_ok       = bus.i_sync_hdr == HDR_WIDTH'(1) || bus.i_sync_hdr == HDR_WIDTH'(2);
    accept       = bus.i_hdr_valid && state_q == TEST_SH;
    sh_inc       = sh_cnt_q + SW'(1);
    inv_inc      = invld_cnt_q + IW'(!hdr_ok);
    sh_full      = sh_inc == SW'(SH_CNT_MAX);
    lose         = accept && lock_q && inv_inc == IW'(SH_INVLD_MAX);
    bad_unlocked = accept && !lock_q && !hdr_ok;
    blank_done   = state_q == SLIP_WAIT && bus.i_hdr_valid && blank_cnt_q == BW'(SLIP_BLANK-1);
  end
  // state register with reset overriding everything, including a pending slip
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= LOCK_INIT;
      lock_q      <= 1'b0;
      slip_q      <= 1'b0;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      slip_q      <= slip_d;
      sh_cnt_q    <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end
  // next state: any slip sends us to blanking, blanking ends after SLIP_BLANK headers
  always_comb begin
    state_d = state_q == LOCK_INIT ? TEST_SH :
              (lose || bad_unlocked) ? SLIP_WAIT :
              blank_done ? TEST_SH : state_q;
  end
  // outputs and counters; loss of lock beats window completion
  always_comb begin
    slip_d      = lose || bad_unlocked;
    lock_d      = lose ? 1'b0 : (accept && !lock_q && hdr_ok && sh_full) ? 1'b1 : lock_q;
    clear       = state_q != TEST_SH || slip_d || (accept && sh_full);
    sh_cnt_d    = clear ? '0 : accept ? sh_inc : sh_cnt_q;
    invld_cnt_d = clear ? '0 : accept ? inv_inc : invld_cnt_q;
    blank_cnt_d = (state_q != SLIP_WAIT || blank_done) ? '0 :
                  bus.i_hdr_valid ? blank_cnt_q + BW'(1) : blank_cnt_q;
  end
  assign bus.o_slip       = slip_q;
  assign bus.o_block_lock = lock_q;
  assign bus.o_sh_cnt     = sh_cnt_q;
  assign bus.o_invld_cnt  = invld_cnt_q;
endmodule

// File: tb/tb_rx_block_lock.sv
// tb_rx_block_lock: randomized directed scenarios checked against a behavioural lock model
module tb_rx_block_lock;
  localparam int SH_MAX = 64, INV_MAX = 16, BLANK = 2;
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_pass = 0;
  int m_sh = 0, m_inv = 0, m_blank = 0;
  bit m_lock = 0, m_slip = 0, m_init = 1, prev_slip = 0;
  bit bad[SH_MAX];
  rx_block_lock_if bus ();
  rx_block_lock #(.SH_CNT_MAX(SH_MAX), .SH_INVLD_MAX(INV_MAX), .SLIP_BLANK(BLANK), .HDR_WIDTH(2))
    dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [1:0] vh();
    return $urandom_range(0, 1) ? 2'b01 : 2'b10;
  endfunction
  function automatic logic [1:0] ih();
    return $urandom_range(0, 1) ? 2'b11 : 2'b00;
  endfunction
  // behavioural reference: one clock edge of the Clause 49 lock rules
  task automatic model(input bit r, input bit v, input logic [1:0] h);
    bit is_bad;
    m_slip = 0;
    if (r) begin
      m_init = 1; m_lock = 0; m_sh = 0; m_inv = 0; m_blank = 0;
    end else if (m_init) begin
      m_init = 0;
    end else if (m_blank > 0) begin
      if (v) m_blank--;
    end else if (v) begin
      is_bad = !(h == 2'b01 || h == 2'b10);
      m_sh++;
      if (is_bad) m_inv++;
      if ((!m_lock && is_bad) || (m_lock && m_inv == INV_MAX)) begin
        m_lock = 0; m_slip = 1; m_sh = 0; m_inv = 0; m_blank = BLANK;
      end else if (m_sh == SH_MAX) begin
        m_lock = 1; m_sh = 0; m_inv = 0;
      end else if (!m_lock) m_inv = 0;
    end
  endtask
  task automatic check();
    n_chk++;
    assert (bus.o_slip === m_slip) n_pass++;
    else $error("FAIL slip t=%0t got %b exp %b", $time, bus.o_slip, m_slip);
    n_chk++;
    assert (bus.o_block_lock === m_lock) n_pass++;
    else $error("FAIL lock t=%0t got %b exp %b", $time, bus.o_block_lock, m_lock);
    n_chk++;
    assert (bus.o_sh_cnt === 7'(m_sh)) n_pass++;
    else $error("FAIL sh_cnt t=%0t got %0d exp %0d", $time, bus.o_sh_cnt, m_sh);
    n_chk++;
    assert (bus.o_invld_cnt === 5'(m_inv)) n_pass++;
    else $error("FAIL invld_cnt t=%0t got %0d exp %0d", $time, bus.o_invld_cnt, m_inv);
    n_chk++;
    assert (!(prev_slip && bus.o_slip === 1'b1)) n_pass++;
    else $error("FAIL slip_back_to_back t=%0t got 1 exp 0", $time);
    prev_slip = bus.o_slip === 1'b1;
  endtask
  task automatic step(input bit r, input bit v, input logic [1:0] h);
    @(negedge clk);
    rst = r; bus.i_hdr_valid = v; bus.i_sync_hdr = h;
    @(posedge clk);
    model(r, v, h);
    #1 check();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 3));
  endtask
  task automatic send(input logic [1:0] h);
    idle($urandom_range(0, 1));
    step(0, 1, h);
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, $urandom_range(0, 1), vh());
    idle(1);
  endtask
  task automatic valid_run(input int n);
    for (int i = 0; i < n; i++) send(vh());
  endtask
  task automatic pick_bad(input int n);
    int p;
    for (int i = 0; i < SH_MAX; i++) bad[i] = 0;
    for (int i = 0; i < n; i++) begin
      do p = $urandom_range(0, SH_MAX - 2); while (bad[p]);
      bad[p] = 1;
    end
  endtask
  task automatic window(input bit gaps);
    for (int i = 0; i < SH_MAX; i++) begin
      if (gaps && i % 8 == 7) idle(5);
      send(bad[i] ? ih() : vh());
    end
  endtask
  initial begin
    bus.i_hdr_valid = 0; bus.i_sync_hdr = 2'b00;
    do_reset(2);
    for (int i = 0; i < SH_MAX; i++) begin
      idle(1);
      step(0, 1, vh());
    end
    do_reset(1);
    valid_run(9);
    send(2'b00);
    valid_run(BLANK);
    valid_run(SH_MAX);
    pick_bad(15);
    window(0);
    pick_bad(16);
    window(0);
    valid_run(BLANK + SH_MAX);
    pick_bad(15);
    bad[SH_MAX-1] = 1;
    window(1);
    valid_run(BLANK + SH_MAX);
    do_reset(1);
    valid_run(40);
    step(1, 1, vh());
    idle(1);
    valid_run(SH_MAX);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0 ? ih() : vh());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
